// File: rtl/mastermind_pkg.sv
// Shared definitions for the mastermind datapath: peg geometry, feedback codes
// and the scorer state encoding.
package mastermind_pkg;

    localparam int NUM_PEGS = 4;
    localparam int COLOR_W  = 3;

    localparam logic [1:0] FB_NONE  = 2'd0;
    localparam logic [1:0] FB_WHITE = 2'd1;
    localparam logic [1:0] FB_BLACK = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXACT   = 2'd1,
        PARTIAL = 2'd2,
        PUBLISH = 2'd3
    } scorer_state_t;

    // Sorted feedback digit k: blacks first, then whites, then blanks.
    function automatic logic [1:0] fb_code(input int k, input logic [2:0] black,
                                           input logic [2:0] white);
        if (k < int'(black))
            return FB_BLACK;
        else if (k < int'(black) + int'(white))
            return FB_WHITE;
        return FB_NONE;
    endfunction

endpackage

// File: rtl/peg_match_finder.sv
// Combinational search for the lowest unconsumed code peg whose colour
// matches one guess peg.
module peg_match_finder
    import mastermind_pkg::*;
(
    input  logic [COLOR_W-1:0]               g_i,
    input  logic [NUM_PEGS-1:0][COLOR_W-1:0] c_i,
    input  logic [NUM_PEGS-1:0]              used_c_i,
    output logic                             found_o,
    output logic [1:0]                       idx_o
);

    // Scanning downwards lets the lowest matching index win.
    always_comb begin
        found_o = 1'b0;
        idx_o   = 2'd0;
        for (int j = NUM_PEGS - 1; j >= 0; j--) begin
            if (!used_c_i[j] && (c_i[j] == g_i)) begin
                found_o = 1'b1;
                idx_o   = 2'(j);
            end
        end
    end

endmodule

// File: rtl/guess_scorer.sv
// Multi-cycle mastermind scorer: exact pass, four partial-match passes, then a
// publish cycle that updates feedback, turn count and win/lose status.
module guess_scorer
    import mastermind_pkg::*;
#(
    parameter int MAX_TURNS = 8,
    parameter int TURN_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_game,
    input  logic               guess_valid,
    output logic               guess_ready,
    input  logic [COLOR_W-1:0] guess0,
    input  logic [COLOR_W-1:0] guess1,
    input  logic [COLOR_W-1:0] guess2,
    input  logic [COLOR_W-1:0] guess3,
    input  logic [COLOR_W-1:0] code0,
    input  logic [COLOR_W-1:0] code1,
    input  logic [COLOR_W-1:0] code2,
    input  logic [COLOR_W-1:0] code3,
    output logic               result_valid,
    output logic [2:0]         black_count,
    output logic [2:0]         white_count,
    output logic [1:0]         fb0,
    output logic [1:0]         fb1,
    output logic [1:0]         fb2,
    output logic [1:0]         fb3,
    output logic [TURN_W-1:0]  turn_count,
    output logic               game_won,
    output logic               game_lost,
    output logic [1:0]         dbg_state
);

    // Handshake: a guess is taken on any clock edge where guess_valid and
    // guess_ready are both high and new_game is low; guess/code are sampled then.
    scorer_state_t state_q, state_d;

    logic [NUM_PEGS-1:0][COLOR_W-1:0] g_q, g_d, c_q, c_d;
    logic [NUM_PEGS-1:0]              used_g_q, used_g_d, used_c_q, used_c_d;
    logic [1:0]                       idx_q, idx_d;
    logic [2:0]                       black_q, black_d, white_q, white_d;

    logic [2:0]                       black_count_q, black_count_d;
    logic [2:0]                       white_count_q, white_count_d;
    logic [NUM_PEGS-1:0][1:0]         fb_q, fb_d;
    logic [TURN_W-1:0]                turn_q, turn_d, turn_inc;
    logic                             won_q, won_d, lost_q, lost_d;

    logic                             accept;
    logic                             match_found;
    logic [1:0]                       match_idx;

    peg_match_finder u_finder (
        .g_i      (g_q[idx_q]),
        .c_i      (c_q),
        .used_c_i (used_c_q),
        .found_o  (match_found),
        .idx_o    (match_idx)
    );

    assign guess_ready = (state_q == IDLE) && !won_q && !lost_q;
    assign accept      = guess_valid && guess_ready && !new_game;
    assign turn_inc    = (turn_q >= TURN_W'(MAX_TURNS)) ? turn_q : turn_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        g_d           = g_q;
        c_d           = c_q;
        used_g_d      = used_g_q;
        used_c_d      = used_c_q;
        idx_d         = idx_q;
        black_d       = black_q;
        white_d       = white_q;
        black_count_d = black_count_q;
        white_count_d = white_count_q;
        fb_d          = fb_q;
        turn_d        = turn_q;
        won_d         = won_q;
        lost_d        = lost_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    g_d      = {guess3, guess2, guess1, guess0};
                    c_d      = {code3, code2, code1, code0};
                    used_g_d = '0;
                    used_c_d = '0;
                    idx_d    = 2'd0;
                    black_d  = 3'd0;
                    white_d  = 3'd0;
                    state_d  = EXACT;
                end
            end
            EXACT: begin
                black_d = 3'd0;
                for (int i = 0; i < NUM_PEGS; i++) begin
                    if (g_q[i] == c_q[i]) begin
                        used_g_d[i] = 1'b1;
                        used_c_d[i] = 1'b1;
                        black_d     = black_d + 3'd1;
                    end
                end
                state_d = PARTIAL;
            end
            PARTIAL: begin
                if (!used_g_q[idx_q] && match_found) begin
                    used_c_d[match_idx] = 1'b1;
                    white_d             = white_q + 3'd1;
                end
                // Results are registered on the way into PUBLISH so they are
                // already visible while result_valid is high.
                if (idx_q == 2'd3) begin
                    state_d       = PUBLISH;
                    black_count_d = black_q;
                    white_count_d = white_d;
                    for (int k = 0; k < NUM_PEGS; k++)
                        fb_d[k] = fb_code(k, black_q, white_d);
                    turn_d = turn_inc;
                    won_d  = (black_q == 3'd4);
                    lost_d = (black_q != 3'd4) && (turn_inc == TURN_W'(MAX_TURNS));
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (new_game) begin
            state_d       = IDLE;
            g_d           = '0;
            c_d           = '0;
            used_g_d      = '0;
            used_c_d      = '0;
            idx_d         = 2'd0;
            black_d       = 3'd0;
            white_d       = 3'd0;
            black_count_d = 3'd0;
            white_count_d = 3'd0;
            fb_d          = '0;
            turn_d        = '0;
            won_d         = 1'b0;
            lost_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            g_q           <= '0;
            c_q           <= '0;
            used_g_q      <= '0;
            used_c_q      <= '0;
            idx_q         <= 2'd0;
            black_q       <= 3'd0;
            white_q       <= 3'd0;
            black_count_q <= 3'd0;
            white_count_q <= 3'd0;
            fb_q          <= '0;
            turn_q        <= '0;
            won_q         <= 1'b0;
            lost_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            g_q           <= g_d;
            c_q           <= c_d;
            used_g_q      <= used_g_d;
            used_c_q      <= used_c_d;
            idx_q         <= idx_d;
            black_q       <= black_d;
            white_q       <= white_d;
            black_count_q <= black_count_d;
            white_count_q <= white_count_d;
            fb_q          <= fb_d;
            turn_q        <= turn_d;
            won_q         <= won_d;
            lost_q        <= lost_d;
        end
    end

    // A clear arriving during PUBLISH suppresses the pulse.
    assign result_valid = (state_q == PUBLISH) && !new_game;
    assign black_count  = black_count_q;
    assign white_count  = white_count_q;
    assign fb0          = fb_q[0];
    assign fb1          = fb_q[1];
    assign fb2          = fb_q[2];
    assign fb3          = fb_q[3];
    assign turn_count   = turn_q;
    assign game_won     = won_q;
    assign game_lost    = lost_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_guess_scorer.sv
// Self-checking bench for guess_scorer: directed scenarios plus randomized
// guesses scored against a colour-count reference model.
module tb_guess_scorer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       new_game = 1'b0;
    logic       guess_valid = 1'b0;
    logic       guess_ready;
    logic [2:0] guess0 = '0, guess1 = '0, guess2 = '0, guess3 = '0;
    logic [2:0] code0 = '0, code1 = '0, code2 = '0, code3 = '0;
    logic       result_valid;
    logic [2:0] black_count, white_count;
    logic [1:0] fb0, fb1, fb2, fb3;
    logic [3:0] turn_count;
    logic       game_won, game_lost;
    logic [1:0] dbg_state;

    guess_scorer #(.MAX_TURNS(8), .TURN_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .new_game     (new_game),
        .guess_valid  (guess_valid),
        .guess_ready  (guess_ready),
        .guess0       (guess0),
        .guess1       (guess1),
        .guess2       (guess2),
        .guess3       (guess3),
        .code0        (code0),
        .code1        (code1),
        .code2        (code2),
        .code3        (code3),
        .result_valid (result_valid),
        .black_count  (black_count),
        .white_count  (white_count),
        .fb0          (fb0),
        .fb1          (fb1),
        .fb2          (fb2),
        .fb3          (fb3),
        .turn_count   (turn_count),
        .game_won     (game_won),
        .game_lost    (game_lost),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // scoreboard: {black, white} per accepted guess
    logic [5:0] exp_q[$];
    int  turn_m = 0;
    bit  won_m  = 0;
    bit  lost_m = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0][2:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    // Reference: black = same-position hits; white = sum over colours of
    // min(guess count, code count) minus black.
    task automatic ref_score(input logic [3:0][2:0] g, input logic [3:0][2:0] c,
                             output int b, output int w);
        int cg[8];
        int cc[8];
        int tot;
        b = 0;
        tot = 0;
        for (int i = 0; i < 8; i++) begin cg[i] = 0; cc[i] = 0; end
        for (int i = 0; i < 4; i++) begin
            if (g[i] == c[i]) b++;
            cg[g[i]]++;
            cc[c[i]]++;
        end
        for (int i = 0; i < 8; i++) tot += (cg[i] < cc[i]) ? cg[i] : cc[i];
        w = tot - b;
    endtask

    function automatic int fb_exp(input int k, input int b, input int w);
        if (k < b) return 2;
        if (k < b + w) return 1;
        return 0;
    endfunction

    // driver tasks
    task automatic clear_game();
        @(negedge clk);
        new_game = 1'b1;
        @(posedge clk);
        #1 new_game = 1'b0;
        turn_m = 0;
        won_m  = 0;
        lost_m = 0;
        exp_q.delete();
    endtask

    task automatic start_guess(input logic [3:0][2:0] g, input logic [3:0][2:0] c,
                               input bit scramble);
        int k;
        int b, w;
        @(negedge clk);
        {guess3, guess2, guess1, guess0} = g;
        {code3, code2, code1, code0}     = c;
        guess_valid = 1'b1;
        k = 0;
        while (!guess_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_accept", guess_ready, 1);
        @(posedge clk);
        #1 guess_valid = 1'b0;
        if (scramble) begin
            {guess3, guess2, guess1, guess0} = 12'($urandom);
            {code3, code2, code1, code0}     = 12'($urandom);
        end
        ref_score(g, c, b, w);
        exp_q.push_back({3'(b), 3'(w)});
    endtask

    task automatic wait_result(input string tag);
        int lat;
        int b, w;
        logic [5:0] e;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            lat = i;
            if (result_valid) break;
        end
        check({tag, "_latency"}, lat, 6);
        if (result_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            b = int'(e[5:3]);
            w = int'(e[2:0]);
            turn_m = (turn_m < 8) ? turn_m + 1 : 8;
            won_m  = (b == 4);
            lost_m = !won_m && (turn_m == 8);
            check({tag, "_black"}, black_count, b);
            check({tag, "_white"}, white_count, w);
            check({tag, "_fb0"}, fb0, fb_exp(0, b, w));
            check({tag, "_fb1"}, fb1, fb_exp(1, b, w));
            check({tag, "_fb2"}, fb2, fb_exp(2, b, w));
            check({tag, "_fb3"}, fb3, fb_exp(3, b, w));
            check({tag, "_turn"}, turn_count, turn_m);
            check({tag, "_won"}, game_won, won_m);
            check({tag, "_lost"}, game_lost, lost_m);
            @(negedge clk);
            check({tag, "_pulse_end"}, result_valid, 0);
            check({tag, "_ready_after"}, guess_ready, !won_m && !lost_m);
        end
    endtask

    task automatic score_guess(input string tag, input logic [3:0][2:0] g,
                               input logic [3:0][2:0] c, input bit scramble);
        start_guess(g, c, scramble);
        wait_result(tag);
    endtask

    initial begin
        int seen;
        logic [3:0][2:0] rg, rc;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", guess_ready, 1);
        check("rst_black", black_count, 0);
        check("rst_fb", {fb3, fb2, fb1, fb0}, 0);
        check("rst_turn", turn_count, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b0;

        score_guess("win", pk(1, 2, 3, 4), pk(1, 2, 3, 4), 0);
        clear_game();
        #1 check("clear_ready", guess_ready, 1);
        check("clear_turn", turn_count, 0);

        score_guess("allwhite", pk(4, 3, 2, 1), pk(1, 2, 3, 4), 0);
        score_guess("dups", pk(1, 2, 1, 1), pk(1, 1, 2, 2), 0);
        score_guess("stable", pk(5, 1, 5, 2), pk(5, 5, 2, 1), 1);

        // eight misses lead to a loss
        clear_game();
        for (int t = 0; t < 8; t++)
            score_guess("loss", pk(7, 7, 7, 7), pk(0, 0, 0, 0), 0);
        check("loss_flag", game_lost, 1);
        check("loss_turn", turn_count, 8);
        @(negedge clk);
        guess_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (result_valid || dbg_state != 2'd0) seen++;
        end
        guess_valid = 1'b0;
        check("loss_no_accept", seen, 0);
        check("loss_turn_frozen", turn_count, 8);

        // abort an in-flight score
        clear_game();
        score_guess("pre_abort", pk(1, 0, 0, 0), pk(0, 1, 2, 3), 0);
        start_guess(pk(1, 2, 3, 4), pk(1, 2, 3, 4), 0);
        repeat (2) @(negedge clk);
        new_game = 1'b1;
        @(posedge clk);
        #1 new_game = 1'b0;
        turn_m = 0; won_m = 0; lost_m = 0;
        exp_q.delete();
        @(negedge clk);
        check("abort_state", dbg_state, 0);
        check("abort_turn", turn_count, 0);
        check("abort_ready", guess_ready, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (result_valid) seen++;
        end
        check("abort_no_result", seen, 0);

        // new_game coincident with PUBLISH
        start_guess(pk(2, 2, 3, 3), pk(2, 3, 3, 2), 0);
        seen = 0;
        for (int i = 0; i < 12 && !result_valid; i++) @(negedge clk);
        new_game = 1'b1;
        #1 check("pub_clear_pulse", result_valid, 0);
        @(posedge clk);
        #1 new_game = 1'b0;
        exp_q.delete();
        check("pub_clear_black", black_count, 0);
        check("pub_clear_turn", turn_count, 0);

        // randomized games
        for (int n = 0; n < 40; n++) begin
            if (won_m || lost_m) clear_game();
            for (int p = 0; p < 4; p++) begin
                rg[p] = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
                rc[p] = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 9) == 0) rg = rc;
            score_guess("rand", rg, rc, 1'($urandom_range(0, 1)));
        end

        // asynchronous reset during PARTIAL
        clear_game();
        score_guess("pre_rst", pk(3, 0, 0, 0), pk(0, 3, 1, 1), 0);
        start_guess(pk(1, 2, 3, 4), pk(1, 2, 4, 3), 0);
        repeat (2) @(negedge clk);
        check("rst_mid_in_partial", dbg_state, 2);
        reset = 1'b1;
        #1;
        check("rst_mid_ready", guess_ready, 1);
        check("rst_mid_turn", turn_count, 0);
        check("rst_mid_counts", {black_count, white_count}, 0);
        check("rst_mid_fb", {fb3, fb2, fb1, fb0}, 0);
        check("rst_mid_state", dbg_state, 0);
        @(negedge clk);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/guess_scorer.md
Name: guess_scorer

Overview:
- Sequential scoring engine for the mastermind game.
- Accepts a committed guess from the turn history over a valid/ready handshake, together with the secret code from the PRNG.
- Computes exact (black) and colour-only (white) matches over a fixed multi-cycle schedule, then publishes sorted per-digit feedback for the seven-segment path.
- Tracks the turn count and win/lose status for the top level.

Parameters:
- COLOR_W, 3, bits per peg colour (8 colours).
- MAX_TURNS, 8, scored guesses allowed before loss (one per sw_led).
- TURN_W, 4, width of turn_count; must hold MAX_TURNS.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- new_game  in  1  synchronous clear of game state; one-cycle pulse
- guess_valid  in  1  guess0..3 and code0..3 are valid
- guess_ready  out  1  scorer can accept a guess
- guess0..guess3  in  COLOR_W each  guessed colours, positions 0..3
- code0..code3  in  COLOR_W each  secret colours, positions 0..3
- result_valid  out  1  one-cycle pulse; outputs below are updated
- black_count  out  3  exact matches, 0..4
- white_count  out  3  colour-only matches, 0..4
- fb0..fb3  out  2 each  sorted feedback: 2=black, 1=white, 0=none
- turn_count  out  TURN_W  number of scored guesses this game
- game_won  out  1  sticky; last score had black_count==4
- game_lost  out  1  sticky; turn_count reached MAX_TURNS without a win

Behaviour:
- Reset: FSM=IDLE; all counts, fb0..fb3, turn_count, result_valid, game_won and game_lost are 0; guess_ready=1.
- guess_ready = (state==IDLE) && !game_won && !game_lost.
- Accept happens on a cycle where guess_valid && guess_ready && !new_game. guess0..3 and code0..3 are latched into internal registers on that cycle; later input changes have no effect.
- FSM states: IDLE -> EXACT -> PARTIAL -> PUBLISH -> IDLE.
- EXACT (1 cycle):
  - For each i, if g[i]==c[i], set used_g[i] and used_c[i].
  - black = popcount of the matches.
- PARTIAL (4 cycles, i = 0..3, 2-bit index):
  - If !used_g[i], select the lowest j with !used_c[j] && g[i]==c[j].
  - If a j is found, set used_c[j] and increment white.
  - Each code peg is consumed at most once, so duplicate colours are handled correctly.
- PUBLISH (1 cycle):
  - Register black_count and white_count.
  - fbk = 2 for k < black; fbk = 1 for black <= k < black+white; otherwise fbk = 0.
  - turn_count increments, saturating at MAX_TURNS.
  - result_valid=1 for this cycle only.
  - game_won is set if black==4.
  - Otherwise game_lost is set if the incremented turn_count==MAX_TURNS.
- Latency: accept at cycle N, result_valid at cycle N+6. The next accept is possible at N+7.
- Result outputs hold their values until the next PUBLISH or a clear.
- Invariant: black_count + white_count <= 4.
- new_game (any state):
  - FSM returns to IDLE and scratch registers are cleared.
  - turn_count, game_won, game_lost, black_count, white_count and fb0..fb3 are cleared to 0.
  - An in-flight score is aborted and produces no result_valid.
  - new_game takes priority over a simultaneous guess_valid, which is not accepted.
- new_game coincident with PUBLISH: the clear wins and result_valid stays 0.
- While game_won or game_lost is set, guesses are refused (guess_ready=0) and all outputs are frozen.
- Asynchronous reset asserted mid-score: immediate return to the reset values.

Decomposition:
- Shared package mastermind_pkg:
  - NUM_PEGS=4, COLOR_W.
  - FB_NONE=0, FB_WHITE=1, FB_BLACK=2.
  - Scorer state encoding: IDLE, EXACT, PARTIAL, PUBLISH.
- One natural sub-module: peg_match_finder. It is combinational: given g[i], c[0..3] and used_c, it returns found and the lowest matching index j. It is instantiated once and reused each PARTIAL cycle.

Test Plan:
- Exact win: code=(1,2,3,4), guess=(1,2,3,4) -> result_valid at accept+6; black=4, white=0; fb=(2,2,2,2); game_won=1; turn_count=1; guess_ready=0.
- All white: code=(1,2,3,4), guess=(4,3,2,1) -> black=0, white=4; fb=(1,1,1,1); game_won=0.
- Duplicates: code=(1,1,2,2), guess=(1,2,1,1) -> black=1, white=2; fb=(2,1,1,0).
- No match plus loss: code=(0,0,0,0), guess=(7,7,7,7) submitted 8 times -> each result is black=0, white=0. After the 8th: turn_count=8, game_lost=1, guess_ready=0. A 9th guess_valid is not accepted.
- Abort: accept a guess, pulse new_game 3 cycles later -> no result_valid; state IDLE next cycle; turn_count=0; guess_ready=1.
- Input stability and reset: change guess and code inputs one cycle after accept -> the result reflects the latched values. Assert reset during PARTIAL -> all outputs 0 immediately and guess_ready=1.
